// File: rtl/mmio_uart_tx_if.sv
// Memory-stage store bus as seen by memory-mapped peripherals.
// The core drives it as master; peripherals decode it as slave.
interface mmio_uart_tx_if;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;

    modport master (output MemWriteM, output DataAdrM, output WriteDataM);
    modport slave  (input  MemWriteM, input  DataAdrM, input  WriteDataM);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to UART_ADDR queue a byte in a TX FIFO,
// and an FSM sends each queued byte as an 8N1 frame on tx.
module mmio_uart_tx #(
    parameter logic [31:0] UART_ADDR    = 32'h0000_0400,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    mmio_uart_tx_if.slave                bus,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [7:0]                   drop_count
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state, state_d;
    logic [BAUD_W-1:0] baud, baud_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic [7:0]        shreg, shreg_d;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [7:0]        mem [FIFO_DEPTH];
    logic              push_req, push_ok, pop;
    logic              fifo_empty, fifo_full, baud_done;
    logic              tx_d, busy_d;
    logic              unused_wdata_hi;

    assign unused_wdata_hi = ^bus.WriteDataM[31:8];

    // Full/empty come from the registered count, so a pop on a full FIFO frees the slot this edge.
    assign push_req   = bus.MemWriteM && (bus.DataAdrM == UART_ADDR);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push_ok    = push_req && (!fifo_full || pop);
    assign baud_done  = (baud == BAUD_W'(CLKS_PER_BIT - 1));

    // Frame sequencing; STOP pops directly into START so frames run back-to-back.
    always_comb begin
        state_d   = state;
        baud_d    = baud;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level and busy follow the current state, one cycle behind the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state != IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !push_ok && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= bus.WriteDataM[7:0];
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench for mmio_uart_tx: a line monitor decodes 8N1 frames and
// compares them with the bytes the stimulus expects to be accepted.
module tb_mmio_uart_tx;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx, busy;
    logic [3:0] fifo_count;
    logic [7:0] drop_count;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .UART_ADDR   (32'h0000_0400),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rst_gen = 0;
    int         nframes = 0;
    int         last_t0 = -1;
    bit         chk_period = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic store(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus.MemWriteM  = we;
        bus.DataAdrM   = adr;
        bus.WriteDataM = dat;
        @(negedge clk);
        bus.MemWriteM  = 1'b0;
    endtask

    // Line monitor: samples mid-bit; frames cut short by reset are discarded.
    initial begin : monitor
        logic [7:0] b;
        int         t0;
        int         gen;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                t0  = cyc;
                gen = rst_gen;
                repeat (CPB / 2) @(negedge clk);
                if (gen == rst_gen) check("start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (gen == rst_gen) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    nframes++;
                    if (chk_period && last_t0 >= 0) check("frame_period", t0 - last_t0, 32'd40);
                    last_t0 = t0;
                    if (exp_q.size() > 0) check("frame_data", {24'h0, b}, {24'h0, exp_q.pop_front()});
                    else                  check("unexpected_frame", {24'h0, b}, 32'h100);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lows;
        int snap;
        bus.MemWriteM  = 1'b0;
        bus.DataAdrM   = '0;
        bus.WriteDataM = '0;

        // Reset and idle line
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        reset = 1'b0;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("idle_line_activity", lows, 32'd0);

        // Single byte: latency, frame and busy timing
        exp_q.push_back(8'h41);
        store(1'b1, 32'h400, 32'h1234_5641);
        @(negedge clk);
        check("tx_after_e1", 32'(tx), 32'd1);
        @(negedge clk);
        check("tx_after_e2", 32'(tx), 32'd0);
        repeat (39) @(negedge clk);
        check("busy_after_e41", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_e42", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("q_drained_single", exp_q.size(), 32'd0);

        // Stores that must be ignored
        store(1'b1, 32'h404, 32'h0000_0077);
        check("other_addr_count", 32'(fifo_count), 32'd0);
        store(1'b0, 32'h400, 32'h0000_0055);
        repeat (3) @(negedge clk);
        check("no_we_count", 32'(fifo_count), 32'd0);
        check("ignored_tx", 32'(tx), 32'd1);
        check("ignored_busy", 32'(busy), 32'd0);

        // Ten back-to-back stores: one pop on E1, then fill to 8, last one dropped
        last_t0    = -1;
        chk_period = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 9) exp_q.push_back(8'(k));
            store(1'b1, 32'h400, 32'hDEAD_BE00 | 32'(k));
            if (k == 8) check("burst_peak_count", 32'(fifo_count), 32'd8);
        end
        check("burst_drop_count", 32'(drop_count), 32'd1);
        repeat (380) @(negedge clk);
        check("q_drained_burst", exp_q.size(), 32'd0);
        chk_period = 1'b0;

        // Overrun: frames pop at E1 and every 40 cycles after, accepting one store each time
        for (int k = 0; k < 309; k++) begin
            if (k <= 8 || (k >= 41 && ((k - 1) % 40) == 0)) exp_q.push_back(8'(k));
            store(1'b1, 32'h400, {$urandom_range(255, 0), 24'h0} | 32'(k[7:0]));
            if (k == 8)   check("overrun_full", 32'(fifo_count), 32'd8);
            if (k == 200) check("overrun_still_full", 32'(fifo_count), 32'd8);
        end
        check("drop_saturated", 32'(drop_count), 32'hFF);
        repeat (450) @(negedge clk);
        check("q_drained_overrun", exp_q.size(), 32'd0);
        check("drop_no_wrap", 32'(drop_count), 32'hFF);

        // Reset during DATA bit 3 with bytes queued
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'hA0 + 8'(k));
            store(1'b1, 32'h400, 32'h0000_00A0 + 32'(k));
        end
        repeat (15) @(negedge clk);
        reset = 1'b1;
        rst_gen++;
        exp_q.delete();
        store(1'b1, 32'h400, 32'h0000_00FF);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_fifo_count", 32'(fifo_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        snap  = nframes;
        repeat (200) @(negedge clk);
        check("no_frames_after_reset", nframes, snap);
        check("post_reset_tx", 32'(tx), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
